// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, divisor and received-byte strobe bundle for uart_rx
interface uart_rx_if #(
    parameter int DATA_W = 8
);
    logic [15:0]       uart_cnt;
    logic              uart_rxd;
    logic              uart_flag;
    logic [DATA_W-1:0] uart_data;
    logic              uart_busy;
    logic              frame_err;

    // line driver / byte consumer side
    modport master (
        output uart_cnt,
        output uart_rxd,
        input  uart_flag,
        input  uart_data,
        input  uart_busy,
        input  frame_err
    );

    // receiver side
    modport slave (
        input  uart_cnt,
        input  uart_rxd,
        output uart_flag,
        output uart_data,
        output uart_busy,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampling UART receiver with stop-bit error strobe
module uart_rx #(
    parameter int DATA_W = 8
) (
    input logic      clk,
    input logic      rst_n,
    uart_rx_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    state_t            next_state;
    logic              s1;
    logic              s2;
    logic              s3;
    logic [15:0]       nl;
    logic [15:0]       baud_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;

    logic fall;
    logic sample;
    logic wrap;
    logic load;
    logic shift_en;
    logic set_flag;
    logic set_err;

    // Falling edge of the synchronised line; s3 lags s2 by one clock.
    assign fall   = s3 & ~s2;
    // Mid-bit sample point and end-of-bit wrap. With nl >= 4 they never coincide.
    assign sample = (baud_cnt == (nl >> 1));
    assign wrap   = (baud_cnt == (nl - 16'd1));

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= bus.uart_rxd;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        set_flag   = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    load       = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (sample && s2) begin
                    next_state = IDLE;
                end else if (wrap) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_en = 1'b1;
                end
                if (wrap && (bit_idx == LAST_IDX)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                // Return to IDLE at mid stop bit so a following start edge is not missed.
                if (sample) begin
                    set_flag   = s2;
                    set_err    = ~s2;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Divisor latch, baud counter and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nl       <= 16'd0;
            baud_cnt <= 16'd0;
            bit_idx  <= '0;
        end else begin
            if (load) begin
                nl <= bus.uart_cnt;
            end
            if (state == IDLE || wrap) begin
                baud_cnt <= 16'd0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (state == DATA && wrap) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // LSB-first shift register: each sampled bit enters at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {s2, shreg[DATA_W-1:1]};
        end
    end

    // Registered outputs: strobes, held byte and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.uart_flag <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.uart_data <= '0;
            bus.uart_busy <= 1'b0;
        end else begin
            bus.uart_flag <= set_flag;
            bus.frame_err <= set_err;
            if (set_flag) begin
                bus.uart_data <= shreg;
            end
            bus.uart_busy <= (next_state != IDLE);
        end
    end
endmodule
